// File: rtl/pipe_stall_sched_pkg.sv
// Shared definitions for the pipe_stall_sched block.
//   DEF_STAGES / DEF_DEPTH : default pipeline depth and output buffer size
//   state_e                : issue/drain control FSM states
package pipe_stall_sched_pkg;

  localparam int DEF_STAGES = 3;
  localparam int DEF_DEPTH  = 4;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_stall_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a registered preference pointer.
// Ports:
//   clk, reset : clock, synchronous active-high reset (pointer -> requester 0)
//   en         : arbitration allowed this cycle; grant is 00 when low
//   req[1:0]   : per-requester request
//   grant[1:0] : combinational one-hot grant (or 00)
//   ptr        : current preferred requester
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // Pointer only moves on a granted cycle, and always to the other requester.
  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pipe_stall_sched.sv
// pipe_stall_sched: issue scheduler for a fixed-latency pipeline feeding a
// small output buffer. Tracks in-flight ops, models buffer occupancy, stalls
// the whole pipeline when the tail op cannot be pushed, and supports a
// drain handshake that halts issue until the pipeline is empty.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   req[1:0]     : issue requests (held until granted)
//   drain_req    : level request to halt issue and empty the pipeline
//   buf_pop      : downstream consumes one buffer entry
//   grant[1:0]   : combinational one-hot grant
//   issue_valid  : op enters stage 0 this cycle
//   stall_output : global pipeline stall
//   occupancy    : modelled buffer fill level
//   drained      : pipeline empty and issue halted
//   pop_err      : sticky, buf_pop seen while buffer empty
module pipe_stall_sched
  import pipe_stall_sched_pkg::*;
#(
  parameter int STAGES = DEF_STAGES,
  parameter int DEPTH  = DEF_DEPTH,
  localparam int OW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic          drain_req,
  input  logic          buf_pop,
  output logic [1:0]    grant,
  output logic          issue_valid,
  output logic          stall_output,
  output logic [OW-1:0] occupancy,
  output logic          drained,
  output logic          pop_err
);

  localparam logic [OW-1:0] FULL = OW'(DEPTH);

  state_e              state_q, state_d;
  logic [STAGES-1:0]   vld_q, vld_d;
  logic [OW-1:0]       occ_q, occ_d;
  logic                pop_err_q, pop_err_d;
  logic                stall, arb_en, push, pop_eff;
  logic                rr_ptr;

  // Stall comes from registered state only: a buf_pop in the same cycle
  // frees a slot for next cycle, costing one bubble. Masked during reset so
  // outputs stay quiet until the cleared state takes effect.
  assign stall   = !reset && vld_q[STAGES-1] && (occ_q == FULL);
  assign arb_en  = !reset && (state_q == ST_RUN) && !stall && !drain_req;
  assign push    = vld_q[STAGES-1] && !stall;
  assign pop_eff = buf_pop && (occ_q != '0);

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .en    (arb_en),
    .req   (req),
    .grant (grant),
    .ptr   (rr_ptr)
  );

  assign issue_valid = |grant;

  always_comb begin
    vld_d = vld_q;
    if (!stall) begin
      vld_d[0] = issue_valid;
      for (int i = 1; i < STAGES; i++) vld_d[i] = vld_q[i-1];
    end
  end

  // push is already suppressed at FULL and pop_eff at zero, so no clamp needed.
  always_comb begin
    occ_d = occ_q;
    if (push && !pop_eff)      occ_d = occ_q + 1'b1;
    else if (!push && pop_eff) occ_d = occ_q - 1'b1;
  end

  assign pop_err_d = pop_err_q || (buf_pop && (occ_q == '0));

  // DRAIN looks at next-cycle pipeline contents so that drained asserts in
  // the first cycle the pipeline is actually empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (drain_req)       state_d = ST_DRAIN;
      ST_DRAIN:   if (vld_d == '0)     state_d = ST_DRAINED;
      ST_DRAINED: if (!drain_req)      state_d = ST_RUN;
      default:                         state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      vld_q     <= '0;
      occ_q     <= '0;
      pop_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      occ_q     <= occ_d;
      pop_err_q <= pop_err_d;
    end
  end

  assign stall_output = stall;
  assign occupancy    = occ_q;
  assign drained      = !reset && (state_q == ST_DRAINED);
  assign pop_err      = pop_err_q;

endmodule

// File: tb/tb_pipe_stall_sched.sv
module tb_pipe_stall_sched;
  import pipe_stall_sched_pkg::*;

  localparam int STAGES = 3;
  localparam int DEPTH  = 4;
  localparam int OW     = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    req = 2'b00;
  logic          drain_req = 1'b0;
  logic          buf_pop = 1'b0;
  logic [1:0]    grant;
  logic          issue_valid, stall_output, drained, pop_err;
  logic [OW-1:0] occupancy;

  int checks = 0;
  int errors = 0;
  logic [1:0] gq[$];

  always #5 clk = ~clk;

  pipe_stall_sched #(.STAGES(STAGES), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .drain_req    (drain_req),
    .buf_pop      (buf_pop),
    .grant        (grant),
    .issue_valid  (issue_valid),
    .stall_output (stall_output),
    .occupancy    (occupancy),
    .drained      (drained),
    .pop_err      (pop_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard side: every cycle the DUT issues, pop the expected grant.
  task automatic monitor();
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (issue_valid) begin
        checks++;
        if (gq.size() == 0) begin
          errors++;
          $display("FAIL grant_unexpected: got %b expected none (t=%0t)", grant, $time);
        end else begin
          e = gq.pop_front();
          if (grant !== e) begin
            errors++;
            $display("FAIL grant: got %b expected %b (t=%0t)", grant, e, $time);
          end
        end
      end
    end
  endtask

  // One cycle of stimulus; eg is the grant expected in this cycle (00 = none).
  task automatic drive(input logic r, input logic [1:0] rq, input logic dr,
                       input logic bp, input logic [1:0] eg);
    @(posedge clk); #1;
    reset = r; req = rq; drain_req = dr; buf_pop = bp;
    if (eg != 2'b00) gq.push_back(eg);
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    fork monitor(); join_none

    // Reset with requests pending: outputs must stay quiet.
    reset = 1'b1; req = 2'b11;
    smp();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_stall", 32'(stall_output), 0);
    chk("rst_drained", 32'(drained), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_pop_err", 32'(pop_err), 0);

    // req=11 from reset: alternating grants until the 5th op stalls at the tail.
    for (int k = 0; k < 7; k++) begin
      drive(0, 2'b11, 0, 0, (k % 2 == 1) ? 2'b10 : 2'b01);
      smp();
      if (k == 6) chk("fill_occ_c6", 32'(occupancy), 3);
    end
    drive(0, 2'b11, 0, 0, 2'b00); smp();
    chk("stall_c7", 32'(stall_output), 1);
    chk("occ_c7", 32'(occupancy), 4);
    chk("grant_c7", 32'(grant), 0);
    drive(0, 2'b11, 0, 0, 2'b00); smp();
    chk("stall_hold", 32'(stall_output), 1);
    chk("vld_hold", 32'(dut.vld_q), 3'b111);

    // One pop while stalled: stall holds this cycle, clears next, tail pushes.
    drive(0, 2'b11, 0, 1, 2'b00); smp();
    chk("pop_stall_same", 32'(stall_output), 1);
    drive(0, 2'b11, 0, 0, 2'b10); smp();
    chk("pop_occ3", 32'(occupancy), 3);
    chk("pop_unstall", 32'(stall_output), 0);
    drive(0, 2'b11, 0, 0, 2'b00); smp();
    chk("pop_occ4", 32'(occupancy), 4);
    chk("pop_restall", 32'(stall_output), 1);

    // Single requester 0 every cycle, then reset mid-flight.
    drive(1, 2'b00, 0, 0, 2'b00); smp();
    for (int k = 0; k < 5; k++) begin
      drive(0, 2'b01, 0, 0, 2'b01); smp();
      if (k == 1) chk("ptr_after_g0", 32'(dut.u_arb.ptr_q), 1);
      chk("iv_single", 32'(issue_valid), 1);
    end
    drive(1, 2'b01, 0, 0, 2'b00); smp();
    chk("pre_rst_vld", 32'(dut.vld_q), 3'b111);
    chk("pre_rst_occ", 32'(occupancy), 2);
    chk("in_rst_grant", 32'(grant), 0);
    drive(0, 2'b00, 0, 0, 2'b00); smp();
    chk("post_rst_occ", 32'(occupancy), 0);
    chk("post_rst_vld", 32'(dut.vld_q), 0);
    chk("post_rst_stall", 32'(stall_output), 0);
    chk("post_rst_state", 32'(dut.state_q), 32'(ST_RUN));
    for (int k = 0; k < 3; k++) begin drive(0, 2'b00, 0, 0, 2'b00); smp(); end
    chk("no_push_after_rst", 32'(occupancy), 0);

    // Round-robin preference follows the last grant.
    drive(0, 2'b01, 0, 0, 2'b01); smp();
    drive(0, 2'b11, 0, 0, 2'b10); smp();
    drive(0, 2'b10, 0, 0, 2'b10); smp();
    drive(0, 2'b11, 0, 0, 2'b01); smp();

    // Drain with three ops in flight.
    drive(1, 2'b00, 0, 0, 2'b00); smp();
    for (int k = 0; k < 3; k++) begin drive(0, 2'b01, 0, 0, 2'b01); smp(); end
    drive(0, 2'b01, 1, 0, 2'b00); smp();
    chk("drain_grant0", 32'(grant), 0);
    chk("drain_vld", 32'(dut.vld_q), 3'b111);
    chk("drain_d0", 32'(drained), 0);
    drive(0, 2'b01, 1, 0, 2'b00); smp();
    chk("drain_d1", 32'(drained), 0);
    drive(0, 2'b01, 1, 0, 2'b00); smp();
    chk("drain_d2", 32'(drained), 0);
    chk("drain_nostall", 32'(stall_output), 0);
    drive(0, 2'b01, 1, 0, 2'b00); smp();
    chk("drain_d3", 32'(drained), 1);
    chk("drain_occ", 32'(occupancy), 3);
    drive(0, 2'b01, 0, 0, 2'b00); smp();
    chk("drained_hold", 32'(drained), 1);
    chk("drained_grant0", 32'(grant), 0);
    drive(0, 2'b01, 0, 0, 2'b01); smp();
    chk("resume_drained", 32'(drained), 0);
    drive(0, 2'b00, 0, 0, 2'b00); smp();

    // Pop from an empty buffer.
    drive(1, 2'b00, 0, 0, 2'b00); smp();
    drive(0, 2'b00, 0, 0, 2'b00); smp();
    chk("pe_clear", 32'(pop_err), 0);
    drive(0, 2'b00, 0, 1, 2'b00); smp();
    drive(0, 2'b00, 0, 0, 2'b00); smp();
    chk("pe_set", 32'(pop_err), 1);
    chk("pe_occ0", 32'(occupancy), 0);
    drive(0, 2'b00, 0, 0, 2'b00); smp();
    drive(0, 2'b00, 0, 0, 2'b00); smp();
    chk("pe_sticky", 32'(pop_err), 1);
    drive(1, 2'b00, 0, 0, 2'b00); smp();
    drive(0, 2'b00, 0, 0, 2'b00); smp();
    chk("pe_rst", 32'(pop_err), 0);

    @(posedge clk); #1;
    chk("grant_queue_empty", 32'(gq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_sched.md
PIPE_STALL_SCHED -- requirements
Module: pipe_stall_sched

Interface
REQ-001 SHALL have parameter: STAGES, default 3, pipeline depth in cycles from issue to buffer push.
REQ-002 SHALL have parameter: DEPTH, default 4, entries in the output buffer behind the pipeline.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: req  input  2  per-requester issue request; held until granted.
REQ-006 SHALL have port: drain_req  input  1  level request to stop issuing and empty the pipeline.
REQ-007 SHALL have port: buf_pop  input  1  downstream consumes one buffer entry this cycle.
REQ-008 SHALL have port: grant  output  2  one-hot grant, combinational, zero or one bit set.
REQ-009 SHALL have port: issue_valid  output  1  op enters pipeline stage 0 this cycle (= |grant).
REQ-010 SHALL have port: stall_output  output  1  global stall to all pipeline stages.
REQ-011 SHALL have port: occupancy  output  clog2(DEPTH+1)  modelled buffer fill level.
REQ-012 SHALL have port: drained  output  1  pipeline empty and issue halted in response to drain_req.
REQ-013 SHALL have port: pop_err  output  1  sticky; buf_pop seen while occupancy==0.

Function
REQ-014 SHALL track in-flight ops in a STAGES-bit valid shift register vld; vld[0] loads issue_valid, tail is vld[STAGES-1].
REQ-015 SHALL drive stall_output = vld[STAGES-1] AND occupancy==DEPTH, from registered state only; same-cycle buf_pop does not clear it (one bubble accepted).
REQ-016 SHALL hold vld, rr pointer and occupancy-push while stall_output=1; only buf_pop changes occupancy then.
REQ-017 SHALL push one entry when vld[STAGES-1]=1 and stall_output=0; occupancy_next = occupancy + push - pop_eff.
REQ-018 SHALL define pop_eff = buf_pop AND occupancy>0; buf_pop at occupancy 0 is ignored and sets pop_err.
REQ-019 SHALL never let occupancy exceed DEPTH or wrap below 0.
REQ-020 SHALL grant only in state RUN with stall_output=0; otherwise grant=00.
REQ-021 SHALL arbitrate round-robin: rr pointer names the preferred requester; if both request, preferred wins; single requester always wins.
REQ-022 SHALL move rr pointer to the other requester of the one granted, only on a cycle with issue_valid=1.
REQ-023 SHALL implement FSM states RUN, DRAIN, DRAINED.
REQ-024 SHALL transition RUN->DRAIN when drain_req=1 (no grant that cycle); DRAIN->DRAINED when vld all zero; DRAINED->RUN when drain_req=0.
REQ-025 SHALL assert drained only in DRAINED; drained does not depend on occupancy.
REQ-026 SHALL, in DRAIN, continue shifting/stalling per REQ-015..017.
REQ-027 SHALL, if drain_req deasserts during DRAIN, complete the drain into DRAINED, then return to RUN next cycle.

Reset
REQ-028 SHALL, on reset, clear vld, occupancy, pop_err, set rr pointer to requester 0, state RUN.
REQ-029 SHALL hold grant=00, issue_valid=0, stall_output=0, drained=0 during and after reset until new state applies.
REQ-030 SHALL discard in-flight ops on reset mid-operation; no push occurs after reset.

Structure
REQ-031 SHALL place the FSM state enum and default STAGES/DEPTH constants in the shared project package.
REQ-032 SHALL instantiate one sub-module rr_arb2 (2-way round-robin arbiter with pointer) for REQ-021/022.

Verification (STAGES=3, DEPTH=4)
REQ-033 SHALL verify: req=11 continuously from reset, no pops -> grants alternate 01,10,01,10; stall_output=1 on cycle when 5th op at tail with occupancy=4.
REQ-034 SHALL verify: stalled state, then buf_pop=1 one cycle -> occupancy 3 next cycle, stall_output drops, held tail pushes, occupancy returns to 4.
REQ-035 SHALL verify: req=01 only -> grant=01 every cycle, issue_valid every cycle, rr pointer toggles to 1 after each grant.
REQ-036 SHALL verify: drain_req=1 with 3 ops in flight -> grant=00 immediately, drained=1 exactly 3 cycles later (no stall), RUN one cycle after drain_req=0.
REQ-037 SHALL verify: buf_pop=1 at occupancy 0 -> occupancy stays 0, pop_err=1 until reset.
REQ-038 SHALL verify: reset asserted with vld=111 and occupancy=2 -> next cycle occupancy=0, vld=000, stall_output=0, state RUN.
